// File: rtl/l2_bus_arbiter.sv
// rtl/l2_bus_arbiter.sv - two-master (icache/dcache) wishbone arbiter onto the shared L2 port
// Round-robin on contention, registered grant, ack/data routed only to the owner.
module l2_bus_arbiter #(
  parameter bit D_FIRST   = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cyc,
  input  logic                 i_stb,
  input  logic                 i_we,
  input  logic [11:0]          i_adr,
  input  logic [15:0]          i_sel,
  input  logic [127:0]         i_dat_m,
  output logic [127:0]         i_dat_s,
  output logic                 i_ack,
  input  logic                 d_cyc,
  input  logic                 d_stb,
  input  logic                 d_we,
  input  logic [11:0]          d_adr,
  input  logic [15:0]          d_sel,
  input  logic [127:0]         d_dat_m,
  output logic [127:0]         d_dat_s,
  output logic                 d_ack,
  output logic                 l2_cyc,
  output logic                 l2_stb,
  output logic                 l2_we,
  output logic [11:0]          l2_adr,
  output logic [15:0]          l2_sel,
  output logic [127:0]         l2_dat_m,
  input  logic [127:0]         l2_dat_s,
  input  logic                 l2_ack,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] contention_count
);

  // State encoding doubles as the grant vector, so grant is a pure register.
  typedef enum logic [1:0] {IDLE = 2'b00, OWN_I = 2'b01, OWN_D = 2'b10} state_t;

  state_t               state_q, state_d;
  logic                 last_d_q, last_d_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic i_req, d_req, own_i, own_d;
  logic unused_ok;

  assign i_req     = i_cyc & i_stb;
  assign d_req     = d_cyc & d_stb;
  assign own_i     = (state_q == OWN_I);
  assign own_d     = (state_q == OWN_D);
  assign unused_ok = ^{i_we, i_dat_m};

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          if (!(&cnt_q)) cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          if (last_d_q) begin
            state_d  = OWN_I;
            last_d_d = 1'b0;
          end else begin
            state_d  = OWN_D;
            last_d_d = 1'b1;
          end
        end else if (i_req) begin
          state_d = OWN_I;
        end else if (d_req) begin
          state_d = OWN_D;
        end
      end
      // Dropping cyc aborts the transaction; l2_ack then or later is swallowed.
      OWN_I:   if (!i_cyc || l2_ack) state_d = IDLE;
      OWN_D:   if (!d_cyc || l2_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= ~D_FIRST;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign l2_cyc   = (own_i & i_cyc) | (own_d & d_cyc);
  assign l2_stb   = l2_cyc;
  assign l2_we    = own_d & d_we;
  assign l2_adr   = own_d ? d_adr : (own_i ? i_adr : '0);
  assign l2_sel   = own_d ? d_sel : (own_i ? i_sel : '0);
  assign l2_dat_m = own_d ? d_dat_m : '0;

  assign i_ack   = own_i & i_cyc & l2_ack;
  assign d_ack   = own_d & d_cyc & l2_ack;
  assign i_dat_s = i_ack ? l2_dat_s : '0;
  assign d_dat_s = d_ack ? l2_dat_s : '0;

  assign grant            = state_q;
  assign contention_count = cnt_q;

endmodule
